geri_yaz: RTL
=============

Name: geri_yaz

Overview:
Writeback stage directly upstream of the core's register file; it drives the file's single write port (address, data, enable). It accepts retiring instructions from the memory stage over a valid/ready handshake. For loads it waits for the data-memory response, then aligns and extends the returned word by funct3. It also produces a registered forwarding copy of the write, a pipeline stall, an error pulse and a retired-instruction counter.

Parameters:
SAYAC_GENISLIK, 64, width of retired-instruction counter emekli_o.
ZAMAN_ASIMI, 255, maximum cycles spent in YUKLE_BEKLE before aborting with hata_o; 0 disables the timeout.

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_ni  input  1  reset; one clock; reset is asynchronous and active-low
gy_gecerli_i  input  1  memory stage presents an instruction
gy_hazir_o  output  1  this stage can accept (handshake fires when gecerli & hazir)
gy_hy_i  input  5  destination register rd
gy_sonuc_i  input  32  ALU/CSR result (non-load)
gy_yaz_i  input  1  instruction writes rd
gy_yukle_i  input  1  instruction is a load
gy_yukle_tur_i  input  3  load funct3
gy_adr_lsb_i  input  2  load address bits [1:0]
bel_gecerli_i  input  1  data-memory response valid (single-cycle pulse)
bel_veri_i  input  32  data-memory read word
bel_hata_i  input  1  memory access fault, qualified by bel_gecerli_i
yaz_adr_o  output  5  register file write address
yaz_deger_o  output  32  register file write data
yaz_o  output  1  register file write enable
yonlendir_gecerli_o  output  1  forwarding valid (yaz_o, forced low when yaz_adr_o==0)
yonlendir_adr_o  output  5  forwarding address (=yaz_adr_o)
yonlendir_deger_o  output  32  forwarding data (=yaz_deger_o)
durdur_o  output  1  stall request to upstream stages
hata_o  output  1  one-cycle pulse: fault, misaligned load, illegal funct3 or timeout
emekli_o  output  SAYAC_GENISLIK  retired-instruction count

Behaviour:
- Reset (async assert, sync-safe release): state BOS, all outputs 0, counters 0, pending load info cleared.
- States: BOS, YUKLE_BEKLE.
- BOS: gy_hazir_o=1, durdur_o=0.
  - Accept non-load: next cycle yaz_o=gy_yaz_i & (gy_hy_i!=0), yaz_adr_o=gy_hy_i, yaz_deger_o=gy_sonuc_i, emekli_o+1. Latency 1 cycle; back-to-back accepts allowed every cycle.
  - Accept load: latch hy, funct3, lsb; if misaligned or illegal, pulse hata_o next cycle, no write, no retire, stay BOS; else go to YUKLE_BEKLE.
  - Misaligned: LH/LHU with lsb[0]=1; LW with lsb!=0.
  - Illegal funct3: 011, 110, 111.
- YUKLE_BEKLE: gy_hazir_o=0, durdur_o=1, timeout counter increments each cycle.
  - On bel_gecerli_i & !bel_hata_i: next cycle yaz_o=(hy!=0), data extracted, emekli_o+1, go to BOS.
  - On bel_gecerli_i & bel_hata_i: next cycle hata_o=1, no write, no retire, go to BOS.
  - Timeout (counter==ZAMAN_ASIMI, nonzero): hata_o pulse, go to BOS.
- yaz_o and hata_o are single-cycle pulses; yaz_adr_o/yaz_deger_o hold their last value when yaz_o=0.
- Extraction (byte k=lsb, half h=lsb[1]):
  - 000 LB: sign-extend byte k.
  - 001 LH: sign-extend half h.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte k.
  - 101 LHU: zero-extend half h.
- bel_gecerli_i in BOS is a stray response and is ignored. A response arriving in the same cycle a load is accepted is also ignored; the earliest valid response is one cycle after accept.
- Reset asserted mid-YUKLE_BEKLE: pending load dropped, no write, counter keeps reset value 0.
- emekli_o wraps modulo 2^SAYAC_GENISLIK.
- Loads and non-loads with rd=x0 still retire; hata cases never retire.

Test Plan:
- Non-load gy_hy_i=5, gy_sonuc_i=32'hDEADBEEF, gy_yaz_i=1 -> next cycle yaz_o=1, adr=5, deger=DEADBEEF, emekli_o=1.
- LB lsb=2, response bel_veri_i=32'h0080_0000 three cycles later -> durdur_o=1 and gy_hazir_o=0 while waiting; then yaz_deger_o=32'hFFFF_FF80, state BOS.
- LHU lsb=2, bel_veri_i=32'hABCD_1234 -> 32'h0000_ABCD. LW lsb=1 -> hata_o pulse, yaz_o=0, emekli_o unchanged.
- Load with bel_hata_i=1 on response -> hata_o=1, yaz_o=0. Separately, no response with ZAMAN_ASIMI=4 -> hata_o after 4 waiting cycles, back to BOS.
- Non-load with rd=0 -> yaz_o=0, yonlendir_gecerli_o=0, emekli_o increments. Stray bel_gecerli_i in BOS -> no effect.
- Assert rst_ni low in YUKLE_BEKLE, then release and send response -> outputs 0, no write. 100 back-to-back non-loads -> emekli_o=100, yaz_o every cycle.

Source files
------------

// File: rtl/geri_yaz.sv
// rtl/geri_yaz.sv - writeback stage driving the register file write port
// Aligns/extends load data, forwards the write, stalls on pending loads, counts retirements.
module geri_yaz #(
  parameter int SAYAC_GENISLIK = 64,
  parameter int ZAMAN_ASIMI    = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      gy_gecerli_i,
  output logic                      gy_hazir_o,
  input  logic [4:0]                gy_hy_i,
  input  logic [31:0]               gy_sonuc_i,
  input  logic                      gy_yaz_i,
  input  logic                      gy_yukle_i,
  input  logic [2:0]                gy_yukle_tur_i,
  input  logic [1:0]                gy_adr_lsb_i,
  input  logic                      bel_gecerli_i,
  input  logic [31:0]               bel_veri_i,
  input  logic                      bel_hata_i,
  output logic [4:0]                yaz_adr_o,
  output logic [31:0]               yaz_deger_o,
  output logic                      yaz_o,
  output logic                      yonlendir_gecerli_o,
  output logic [4:0]                yonlendir_adr_o,
  output logic [31:0]               yonlendir_deger_o,
  output logic                      durdur_o,
  output logic                      hata_o,
  output logic [SAYAC_GENISLIK-1:0] emekli_o
);

  localparam int TW = (ZAMAN_ASIMI > 1) ? $clog2(ZAMAN_ASIMI + 1) : 1;

  typedef enum logic {BOS, YUKLE_BEKLE} durum_t;

  durum_t        durum_q;
  logic [4:0]    hy_q;
  logic [2:0]    tur_q;
  logic [1:0]    lsb_q;
  logic [TW-1:0] zaman_q;
  logic [TW:0]   zaman_sonraki;
  logic          kabul;

  assign kabul         = gy_gecerli_i & gy_hazir_o;
  assign zaman_sonraki = {1'b0, zaman_q} + 1'b1;

  assign yonlendir_gecerli_o = yaz_o & (yaz_adr_o != 5'd0);
  assign yonlendir_adr_o     = yaz_adr_o;
  assign yonlendir_deger_o   = yaz_deger_o;

  function automatic logic [31:0] cikar(input logic [2:0] tur, input logic [1:0] lsb,
                                        input logic [31:0] w);
    logic [31:0] s;
    logic [7:0]  b;
    logic [15:0] h;
    s = w >> {lsb, 3'b000};
    b = s[7:0];
    h = lsb[1] ? w[31:16] : w[15:0];
    case (tur)
      3'b000:  cikar = {{24{b[7]}}, b};
      3'b001:  cikar = {{16{h[15]}}, h};
      3'b100:  cikar = {24'd0, b};
      3'b101:  cikar = {16'd0, h};
      default: cikar = w;
    endcase
  endfunction

  // Misaligned halfword/word accesses and the unused funct3 codes are rejected at accept.
  function automatic logic hatali(input logic [2:0] tur, input logic [1:0] lsb);
    case (tur)
      3'b000, 3'b100: hatali = 1'b0;
      3'b001, 3'b101: hatali = lsb[0];
      3'b010:         hatali = (lsb != 2'd0);
      default:        hatali = 1'b1;
    endcase
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      durum_q     <= BOS;
      hy_q        <= '0;
      tur_q       <= '0;
      lsb_q       <= '0;
      zaman_q     <= '0;
      gy_hazir_o  <= 1'b0;
      durdur_o    <= 1'b0;
      yaz_o       <= 1'b0;
      yaz_adr_o   <= '0;
      yaz_deger_o <= '0;
      hata_o      <= 1'b0;
      emekli_o    <= '0;
    end else begin
      yaz_o  <= 1'b0;
      hata_o <= 1'b0;
      case (durum_q)
        BOS: begin
          gy_hazir_o <= 1'b1;
          durdur_o   <= 1'b0;
          if (kabul) begin
            if (gy_yukle_i) begin
              hy_q    <= gy_hy_i;
              tur_q   <= gy_yukle_tur_i;
              lsb_q   <= gy_adr_lsb_i;
              zaman_q <= '0;
              if (hatali(gy_yukle_tur_i, gy_adr_lsb_i)) begin
                hata_o <= 1'b1;
              end else begin
                durum_q    <= YUKLE_BEKLE;
                gy_hazir_o <= 1'b0;
                durdur_o   <= 1'b1;
              end
            end else begin
              yaz_o       <= gy_yaz_i & (gy_hy_i != 5'd0);
              yaz_adr_o   <= gy_hy_i;
              yaz_deger_o <= gy_sonuc_i;
              emekli_o    <= emekli_o + 1'b1;
            end
          end
        end
        YUKLE_BEKLE: begin
          zaman_q <= zaman_sonraki[TW-1:0];
          // A response landing on the timeout edge still completes the load.
          if (bel_gecerli_i) begin
            durum_q    <= BOS;
            gy_hazir_o <= 1'b1;
            durdur_o   <= 1'b0;
            if (bel_hata_i) begin
              hata_o <= 1'b1;
            end else begin
              yaz_o       <= (hy_q != 5'd0);
              yaz_adr_o   <= hy_q;
              yaz_deger_o <= cikar(tur_q, lsb_q, bel_veri_i);
              emekli_o    <= emekli_o + 1'b1;
            end
          end else if ((ZAMAN_ASIMI != 0) && (zaman_sonraki == (TW+1)'(ZAMAN_ASIMI))) begin
            durum_q    <= BOS;
            gy_hazir_o <= 1'b1;
            durdur_o   <= 1'b0;
            hata_o     <= 1'b1;
          end
        end
        default: durum_q <= BOS;
      endcase
    end
  end

endmodule
